// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg
// Shared types for the SPI RAM burst block: command opcodes, FSM states and
// a small width helper used to size the command payload.
package spi_ram_pkg;

    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } op_t;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_TX_WAIT = 1'b1
    } state_t;

    function automatic int max_width(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_ram_mem.sv
// spi_ram_mem
// Plain storage array: synchronous write, combinational read. No reset.
// Ports:
//   clk    - write clock
//   we     - write enable (caller guarantees waddr is in range)
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data (combinational)
module spi_ram_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/spi_ram_burst.sv
// spi_ram_burst
// Parametrised single-port RAM between the SPI slave receive path and the
// MISO serialiser. Commands arrive on din/rx_valid; read data leaves on
// dout with a tx_valid/tx_ready handshake that is abandoned after TX_TIMEOUT
// cycles without acceptance.
// Optional feature macro: SPI_RAM_AUTOINC_EN (pointer post-increment with
// wrap at MEM_DEPTH-1).
// Ports:
//   clk         - clock, rising edge
//   rst         - asynchronous active-high reset
//   din         - {opcode[1:0], payload[PAY_W-1:0]}
//   rx_valid    - din holds a command this cycle
//   tx_ready    - downstream accepts dout
//   dout        - read data
//   tx_valid    - dout valid
//   busy        - high while waiting for the TX handshake
//   err_addr    - pulse: WR_DATA/RD_DATA to an address >= MEM_DEPTH
//   err_busy    - pulse: RD_DATA dropped while busy
//   err_timeout - pulse: TX word dropped by timeout
module spi_ram_burst
    import spi_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_DEPTH  = 256,
    parameter int TX_TIMEOUT = 8,
    localparam int PAY_W     = max_width(DATA_WIDTH, ADDR_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PAY_W+1:0]      din,
    input  logic                  rx_valid,
    input  logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  tx_valid,
    output logic                  busy,
    output logic                  err_addr,
    output logic                  err_busy,
    output logic                  err_timeout
);

    localparam int CNT_W = $clog2(TX_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(TX_TIMEOUT - 1);
    // One extra bit so MEM_DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

    state_t                  state, state_n;
    logic [ADDR_WIDTH-1:0]   wr_addr, wr_addr_n;
    logic [ADDR_WIDTH-1:0]   rd_addr, rd_addr_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic [DATA_WIDTH-1:0]   dout_n;
    logic                    tx_valid_n;
    logic                    err_addr_n, err_busy_n, err_timeout_n;

    op_t                     op;
    logic [PAY_W-1:0]        payload;
    logic                    wr_in_range, rd_in_range;
    logic                    mem_we;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    assign op          = op_t'(din[PAY_W+1:PAY_W]);
    assign payload     = din[PAY_W-1:0];
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_EXT);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_EXT);
    assign busy        = (state == ST_TX_WAIT);

`ifdef SPI_RAM_AUTOINC_EN
    function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + ADDR_WIDTH'(1);
    endfunction
`endif

    spi_ram_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_addr),
        .wdata (payload[DATA_WIDTH-1:0]),
        .raddr (rd_addr),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            wr_addr     <= '0;
            rd_addr     <= '0;
            cnt         <= '0;
            dout        <= '0;
            tx_valid    <= 1'b0;
            err_addr    <= 1'b0;
            err_busy    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            wr_addr     <= wr_addr_n;
            rd_addr     <= rd_addr_n;
            cnt         <= cnt_n;
            dout        <= dout_n;
            tx_valid    <= tx_valid_n;
            err_addr    <= err_addr_n;
            err_busy    <= err_busy_n;
            err_timeout <= err_timeout_n;
        end
    end

    always_comb begin
        state_n       = state;
        wr_addr_n     = wr_addr;
        rd_addr_n     = rd_addr;
        cnt_n         = cnt;
        dout_n        = dout;
        tx_valid_n    = tx_valid;
        err_addr_n    = 1'b0;
        err_busy_n    = 1'b0;
        err_timeout_n = 1'b0;
        mem_we        = 1'b0;

        // Pointer and write commands execute in either state.
        if (rx_valid) begin
            case (op)
                OP_WR_ADDR: wr_addr_n = payload[ADDR_WIDTH-1:0];
                OP_WR_DATA: begin
                    if (wr_in_range) begin
                        mem_we = 1'b1;
                    end else begin
                        err_addr_n = 1'b1;
                    end
`ifdef SPI_RAM_AUTOINC_EN
                    wr_addr_n = next_ptr(wr_addr);
`endif
                end
                OP_RD_ADDR: rd_addr_n = payload[ADDR_WIDTH-1:0];
                default: ;
            endcase
        end

        case (state)
            ST_IDLE: begin
                if (rx_valid && op == OP_RD_DATA) begin
                    dout_n     = rd_in_range ? mem_rdata : '0;
                    err_addr_n = !rd_in_range;
                    tx_valid_n = 1'b1;
                    cnt_n      = '0;
                    state_n    = ST_TX_WAIT;
`ifdef SPI_RAM_AUTOINC_EN
                    rd_addr_n  = next_ptr(rd_addr);
`endif
                end
            end
            ST_TX_WAIT: begin
                if (rx_valid && op == OP_RD_DATA) begin
                    err_busy_n = 1'b1;
                end
                if (tx_ready) begin
                    tx_valid_n = 1'b0;
                    state_n    = ST_IDLE;
                end else if (cnt == CNT_LAST) begin
                    tx_valid_n    = 1'b0;
                    err_timeout_n = 1'b1;
                    state_n       = ST_IDLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_ram_burst.sv
// tb_spi_ram_burst
// Directed bench for spi_ram_burst (MEM_DEPTH=200). Read data is checked by a
// scoreboard: each RD_DATA that should be delivered pushes its expected word,
// and a monitor pops/compares on every tx_valid&&tx_ready handshake.
module tb_spi_ram_burst;
    import spi_ram_pkg::*;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 200;
    localparam int TMO   = 8;
    localparam int PW    = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [PW+1:0] din = '0;
    logic          rx_valid = 1'b0;
    logic          tx_ready = 1'b0;
    logic [DW-1:0] dout;
    logic          tx_valid, busy, err_addr, err_busy, err_timeout;

    int unsigned   n_pass  = 0;
    int unsigned   n_total = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    spi_ram_burst #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MEM_DEPTH  (DEPTH),
        .TX_TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .rx_valid    (rx_valid),
        .tx_ready    (tx_ready),
        .dout        (dout),
        .tx_valid    (tx_valid),
        .busy        (busy),
        .err_addr    (err_addr),
        .err_busy    (err_busy),
        .err_timeout (err_timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Called just after a rising edge; presents one command for one cycle.
    task automatic send(input op_t op, input logic [PW-1:0] pay);
        din      = {op, pay};
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        din      = '0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Read with tx_ready high: word must appear 1 cycle after RD_DATA and
    // be consumed by the following edge.
    task automatic read_expect(input logic [DW-1:0] exp, input string name);
        exp_q.push_back(exp);
        send(OP_RD_DATA, '0);
        chk({name, " tx_valid"}, {31'd0, tx_valid}, 32'd1);
        idle(1);
        chk({name, " released"}, {31'd0, tx_valid}, 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_word: got 0x%0h expected none", dout);
            end else begin
                chk("scoreboard dout", {24'd0, dout}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;

        // Reset values
        #12;
        chk("reset flags", {27'd0, tx_valid, busy, err_addr, err_busy, err_timeout}, 32'd0);
        chk("reset dout", {24'd0, dout}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic write/read with immediate handshake
        tx_ready = 1'b1;
        send(OP_WR_ADDR, 8'h05);
        send(OP_WR_DATA, 8'hA5);
        send(OP_RD_ADDR, 8'h05);
        exp_q.push_back(8'hA5);
        send(OP_RD_DATA, '0);
        chk("t1 tx_valid latency", {31'd0, tx_valid}, 32'd1);
        chk("t1 busy", {31'd0, busy}, 32'd1);
        idle(1);
        chk("t1 tx_valid drop", {31'd0, tx_valid}, 32'd0);
        chk("t1 busy drop", {31'd0, busy}, 32'd0);
        chk("t1 dout hold", {24'd0, dout}, 32'hA5);

        // Timeout: word dropped after TX_TIMEOUT cycles
        tx_ready = 1'b0;
        send(OP_RD_ADDR, 8'h05);
        send(OP_RD_DATA, '0);
        n = 0;
        while (tx_valid && n < 20) begin
            n++;
            idle(1);
        end
        chk("t2 tx_valid cycles", n, TMO);
        chk("t2 err_timeout", {31'd0, err_timeout}, 32'd1);
        chk("t2 busy", {31'd0, busy}, 32'd0);
        idle(1);
        chk("t2 err_timeout pulse", {31'd0, err_timeout}, 32'd0);

        // Commands while busy
        send(OP_RD_ADDR, 8'h05);
        exp_q.push_back(8'hA5);
        send(OP_RD_DATA, '0);
        chk("t3 busy", {31'd0, busy}, 32'd1);
        send(OP_WR_ADDR, 8'h20);
        send(OP_RD_DATA, '0);
        chk("t3 err_busy", {31'd0, err_busy}, 32'd1);
        send(OP_WR_DATA, 8'h3C);
        chk("t3 err_busy pulse", {31'd0, err_busy}, 32'd0);
        chk("t3 still valid", {31'd0, tx_valid}, 32'd1);
        tx_ready = 1'b1;
        idle(1);
        chk("t3 delivered", {31'd0, tx_valid}, 32'd0);
        send(OP_RD_ADDR, 8'h20);
        read_expect(8'h3C, "t3 readback");

        // Write then read same address on the next cycle
        send(OP_WR_ADDR, 8'h30);
        send(OP_RD_ADDR, 8'h30);
        send(OP_WR_DATA, 8'h99);
        read_expect(8'h99, "t4 wr->rd");

        // Out of range accesses
        send(OP_WR_ADDR, 8'h50);
        send(OP_WR_DATA, 8'h77);
        chk("t5 in-range no err", {31'd0, err_addr}, 32'd0);
        send(OP_WR_ADDR, 8'hD0);
        chk("t5 wr_addr load no err", {31'd0, err_addr}, 32'd0);
        send(OP_WR_DATA, 8'h11);
        chk("t5 wr err_addr", {31'd0, err_addr}, 32'd1);
        send(OP_RD_ADDR, 8'hD0);
        chk("t5 rd_addr load no err", {31'd0, err_addr}, 32'd0);
        exp_q.push_back(8'h00);
        send(OP_RD_DATA, '0);
        chk("t5 rd err_addr", {31'd0, err_addr}, 32'd1);
        chk("t5 rd tx_valid", {31'd0, tx_valid}, 32'd1);
        idle(1);
        send(OP_RD_ADDR, 8'h50);
        read_expect(8'h77, "t5 alias untouched");

        // Last valid address
        send(OP_WR_ADDR, 8'hC7);
        send(OP_WR_DATA, 8'h5A);
        chk("t6 last addr no err", {31'd0, err_addr}, 32'd0);
        send(OP_RD_ADDR, 8'hC7);
        read_expect(8'h5A, "t6 last addr");

`ifdef SPI_RAM_AUTOINC_EN
        // Both pointers wrapped from 199 to 0
        send(OP_WR_DATA, 8'h02);
        chk("t7 wrapped wr no err", {31'd0, err_addr}, 32'd0);
        read_expect(8'h02, "t7 wrapped rd");
        send(OP_RD_ADDR, 8'hC7);
        read_expect(8'h5A, "t7 burst 0");
        read_expect(8'h02, "t7 burst 1");
`endif

        // Reset during TX_WAIT drops the word asynchronously
        tx_ready = 1'b0;
        send(OP_RD_ADDR, 8'h20);
        send(OP_RD_DATA, '0);
        chk("t8 busy before rst", {31'd0, busy}, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("t8 async flags", {30'd0, tx_valid, busy}, 32'd0);
        chk("t8 async dout", {24'd0, dout}, 32'd0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        tx_ready = 1'b1;
        send(OP_RD_ADDR, 8'h20);
        read_expect(8'h3C, "t8 ram kept 20");
        send(OP_RD_ADDR, 8'h05);
        read_expect(8'hA5, "t8 ram kept 05");

        chk("scoreboard drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
